// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider-sharing scheduler: FSM encodings and constants.
package div_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_ISSUE = 2'd1;
   localparam state_t S_BUSY  = 2'd2;
   localparam state_t S_RESP  = 2'd3;

   localparam int DEF_TIMEOUT = 64;

   // All-ones quotient returned for divide-by-zero; sliced down to the operand width.
   localparam logic [127:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_share_arb_if.sv
// Request, response and divider-side signals of div_share_arb bundled in one interface.
interface div_share_arb_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_dividend;
   logic [NREQ*WIDTH-1:0] req_divisor;
   logic [NREQ-1:0]       req_sign;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_q;
   logic [WIDTH-1:0]      rsp_r;
   logic                  rsp_sign;
   logic                  rsp_dz;
   logic                  rsp_err;

   logic [WIDTH-1:0]      div_zdividend;
   logic [WIDTH-1:0]      div_zdivisor;
   logic                  div_sign;
   logic                  div_valid_in;
   logic                  div_free;
   logic                  div_done;
   logic [WIDTH-1:0]      div_q;
   logic [WIDTH-1:0]      div_r;
   logic                  div_sign_o;

   // slave is the scheduler itself; master is everything around it (requesters, sink, divider).
   modport slave (
      input  req_valid, req_dividend, req_divisor, req_sign, rsp_ready,
             div_free, div_done, div_q, div_r, div_sign_o,
      output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_sign, rsp_dz, rsp_err,
             div_zdividend, div_zdivisor, div_sign, div_valid_in
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_sign, rsp_ready,
             div_free, div_done, div_q, div_r, div_sign_o,
      input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_sign, rsp_dz, rsp_err,
             div_zdividend, div_zdivisor, div_sign, div_valid_in
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping, as one-hot and index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int cand;

   // The last winner is searched last, so every requester is reached within NREQ grants.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = (int'(ptr) + i) % NREQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/div_share_arb.sv
// Round-robin scheduler sharing one radix-2 divider between NREQ requesters, one op at a time.
module div_share_arb
   import div_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic           clk,
   input logic           rst_n,
   div_share_arb_if.slave bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int TW  = $clog2(TIMEOUT + 1);

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   id;
   logic [WIDTH-1:0] opa, opb, q_reg, r_reg;
   logic             sgn, sign_reg, dz_reg, err_reg;
   logic [TW-1:0]    timer;

   logic [NREQ-1:0]  pick_grant;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic [WIDTH-1:0] sel_dividend, sel_divisor;
   logic             sel_sign, timer_hit;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign sel_dividend = bus.req_dividend[int'(pick_idx)*WIDTH +: WIDTH];
   assign sel_divisor  = bus.req_divisor[int'(pick_idx)*WIDTH +: WIDTH];
   assign sel_sign     = bus.req_sign[pick_idx];
   assign timer_hit    = (timer == TW'(TIMEOUT - 1));

   // Single outstanding operation; the watchdog covers both a divider that never frees and one that never finishes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= IDW'(NREQ - 1);
         id       <= '0;
         opa      <= '0;
         opb      <= '0;
         sgn      <= 1'b0;
         q_reg    <= '0;
         r_reg    <= '0;
         sign_reg <= 1'b0;
         dz_reg   <= 1'b0;
         err_reg  <= 1'b0;
         timer    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  id    <= pick_idx;
                  opa   <= sel_dividend;
                  opb   <= sel_divisor;
                  sgn   <= sel_sign;
                  timer <= '0;
                  if (sel_divisor == '0) begin
                     q_reg    <= DZ_QUOT[WIDTH-1:0];
                     r_reg    <= sel_dividend;
                     sign_reg <= sel_sign;
                     dz_reg   <= 1'b1;
                     err_reg  <= 1'b0;
                     state    <= S_RESP;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.div_free) begin
                  timer <= '0;
                  state <= S_BUSY;
               end else if (timer_hit) begin
                  q_reg    <= '0;
                  r_reg    <= '0;
                  sign_reg <= 1'b0;
                  dz_reg   <= 1'b0;
                  err_reg  <= 1'b1;
                  state    <= S_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_BUSY: begin
               if (bus.div_done) begin
                  q_reg    <= bus.div_q;
                  r_reg    <= bus.div_r;
                  sign_reg <= bus.div_sign_o;
                  dz_reg   <= 1'b0;
                  err_reg  <= 1'b0;
                  state    <= S_RESP;
               end else if (timer_hit) begin
                  q_reg    <= '0;
                  r_reg    <= '0;
                  sign_reg <= 1'b0;
                  dz_reg   <= 1'b0;
                  err_reg  <= 1'b1;
                  state    <= S_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  ptr   <= id;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (state == S_IDLE) ? pick_grant : '0;
   assign bus.rsp_valid     = (state == S_RESP);
   assign bus.rsp_id        = id;
   assign bus.rsp_q         = q_reg;
   assign bus.rsp_r         = r_reg;
   assign bus.rsp_sign      = sign_reg;
   assign bus.rsp_dz        = dz_reg;
   assign bus.rsp_err       = err_reg;
   assign bus.div_valid_in  = (state == S_ISSUE);
   assign bus.div_zdividend = opa;
   assign bus.div_zdivisor  = opb;
   assign bus.div_sign      = sgn;

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with a small behavioural divider model on the divider side.
module tb_div_share_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic        model_free_en = 1'b1;
   logic        model_hang    = 1'b0;
   logic        force_done    = 1'b0;
   logic        busy_m        = 1'b0;
   logic        model_done    = 1'b0;
   int          lat           = 0;
   logic [31:0] mq = '0, mr = '0;
   logic        ms = 1'b0;

   div_share_arb_if #(.WIDTH(32), .NREQ(4)) bus ();

   div_share_arb #(.WIDTH(32), .NREQ(4), .TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Divider stand-in: accepts on valid_in && free, pulses done a few cycles later unless hung.
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (!busy_m) begin
         if (bus.div_valid_in && bus.div_free) begin
            busy_m <= 1'b1;
            lat    <= 2;
            mq     <= bus.div_zdividend / bus.div_zdivisor;
            mr     <= bus.div_zdividend % bus.div_zdivisor;
            ms     <= bus.div_sign & (bus.div_zdividend[31] ^ bus.div_zdivisor[31]);
         end
      end else if (lat == 0) begin
         busy_m     <= 1'b0;
         model_done <= !model_hang;
      end else begin
         lat <= lat - 1;
      end
   end

   assign bus.div_free   = !busy_m && model_free_en;
   assign bus.div_done   = model_done | force_done;
   assign bus.div_q      = mq;
   assign bus.div_r      = mr;
   assign bus.div_sign_o = ms;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[i]             = v;
      bus.req_dividend[i*32 +: 32] = a;
      bus.req_divisor[i*32 +: 32]  = b;
      bus.req_sign[i]              = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      step();
      n_cmp++;
      if ({bus.rsp_valid, bus.div_valid_in, bus.req_ready, bus.rsp_id, bus.rsp_dz, bus.rsp_err} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_ctrl: got valid=%b dvi=%b rdy=%b id=%0d dz=%b err=%b want all 0",
                  bus.rsp_valid, bus.div_valid_in, bus.req_ready, bus.rsp_id, bus.rsp_dz, bus.rsp_err);
      end
      n_cmp++;
      if ({bus.rsp_q, bus.rsp_r, bus.div_zdividend, bus.div_zdivisor} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_data: got q=%h r=%h a=%h b=%h want 0",
                  bus.rsp_q, bus.rsp_r, bus.div_zdividend, bus.div_zdivisor);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int k;
      do_reset();
      set_req(0, 1'b1, 32'd100, 32'd7);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_grant: got %b want 0001", bus.req_ready); end
      step();
      set_req(0, 1'b0, 32'd0, 32'd0);
      #1;
      n_cmp++;
      if ({bus.div_valid_in, bus.div_zdividend, bus.div_zdivisor, bus.req_ready} !== {1'b1, 32'd100, 32'd7, 4'b0000}) begin
         n_bad++;
         $display("[TB] FAIL single_issue: got dvi=%b a=%0d b=%0d rdy=%b want 1/100/7/0000",
                  bus.div_valid_in, bus.div_zdividend, bus.div_zdivisor, bus.req_ready);
      end
      step();
      n_cmp++;
      if (bus.div_valid_in !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy: got dvi=%b want 0", bus.div_valid_in); end
      k = 0;
      while (bus.div_done !== 1'b1 && k < 20) begin step(); k++; end
      n_cmp++;
      if (k >= 20) begin n_bad++; $display("[TB] FAIL single_done_wait: got no div_done want done within 20"); end
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_early: got rsp_valid=%b want 0", bus.rsp_valid); end
      step();
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dz, bus.rsp_err} !== {1'b1, 32'd14, 32'd2, 2'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL single_rsp: got v=%b q=%0d r=%0d id=%0d dz=%b err=%b want 1/14/2/0/0/0",
                  bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dz, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_release: got rsp_valid=%b want 0", bus.rsp_valid); end
   endtask

   task automatic test_round_robin();
      int got[5];
      int exp_ord[5];
      int ng;
      int cyc;
      exp_ord = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'd40 + 32'(i), 32'd5);
      bus.rsp_ready = 1'b1;
      ng  = 0;
      cyc = 0;
      while (ng < 5 && cyc < 200) begin
         #1;
         if (bus.req_ready !== 4'b0000) begin
            n_cmp++;
            if ($countones(bus.req_ready) != 1) begin
               n_bad++;
               $display("[TB] FAIL rr_onehot: got %b want one-hot", bus.req_ready);
            end
            got[ng] = -1;
            for (int i = 0; i < 4; i++) if (bus.req_ready[i]) got[ng] = i;
            ng++;
         end
         step();
         cyc++;
      end
      n_cmp++;
      if (ng != 5) begin n_bad++; $display("[TB] FAIL rr_count: got %0d grants want 5", ng); end
      for (int i = 0; i < ng; i++) begin
         n_cmp++;
         if (got[i] != exp_ord[i]) begin
            n_bad++;
            $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, got[i], exp_ord[i]);
         end
      end
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'd0, 32'd0);
      cyc = 0;
      while (bus.rsp_valid !== 1'b1 && cyc < 50) begin step(); cyc++; end
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_div_zero();
      set_req(2, 1'b1, 32'h1234, 32'd0);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0100) begin n_bad++; $display("[TB] FAIL dz_grant: got %b want 0100", bus.req_ready); end
      step();
      set_req(2, 1'b0, 32'd0, 32'd0);
      #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.div_valid_in, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_id, bus.rsp_err}
          !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2'd2, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL dz_rsp: got v=%b dvi=%b q=%h r=%h dz=%b id=%0d err=%b want 1/0/ffffffff/1234/1/2/0",
                  bus.rsp_valid, bus.div_valid_in, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_id, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL dz_release: got rsp_valid=%b want 0", bus.rsp_valid); end
   endtask

   task automatic test_issue_stall();
      int k;
      model_free_en = 1'b0;
      set_req(3, 1'b1, 32'd10, 32'd3);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b1000) begin n_bad++; $display("[TB] FAIL stall_grant: got %b want 1000", bus.req_ready); end
      step();
      set_req(3, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if ({bus.div_valid_in, bus.div_zdividend, bus.div_zdivisor} !== {1'b1, 32'd10, 32'd3}) begin
            n_bad++;
            $display("[TB] FAIL stall_hold[%0d]: got dvi=%b a=%0d b=%0d want 1/10/3",
                     i, bus.div_valid_in, bus.div_zdividend, bus.div_zdivisor);
         end
         step();
      end
      model_free_en = 1'b1;
      #1;
      n_cmp++;
      if (bus.div_valid_in !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_last: got dvi=%b want 1", bus.div_valid_in); end
      step();
      n_cmp++;
      if (bus.div_valid_in !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_busy: got dvi=%b want 0", bus.div_valid_in); end
      k = 0;
      while (bus.rsp_valid !== 1'b1 && k < 20) begin step(); k++; end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 32'd3, 32'd1, 2'd3}) begin
         n_bad++;
         $display("[TB] FAIL stall_rsp: got v=%b q=%0d r=%0d id=%0d want 1/3/1/3",
                  bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      model_hang = 1'b1;
      set_req(1, 1'b1, 32'd20, 32'd4);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0010) begin n_bad++; $display("[TB] FAIL to_grant: got %b want 0010", bus.req_ready); end
      step();
      set_req(1, 1'b0, 32'd0, 32'd0);
      step();
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 100) begin step(); n++; end
      n_cmp++;
      if (n != 64) begin n_bad++; $display("[TB] FAIL to_latency: got %0d cycles want 64", n); end
      n_cmp++;
      if ({bus.rsp_err, bus.rsp_dz, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 1'b0, 32'd0, 32'd0, 2'd1}) begin
         n_bad++;
         $display("[TB] FAIL to_rsp: got err=%b dz=%b q=%0d r=%0d id=%0d want 1/0/0/0/1",
                  bus.rsp_err, bus.rsp_dz, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      model_hang = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, 32'd9, 32'd2);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_bad++; $display("[TB] FAIL to_next_grant: got %b want 0001", bus.req_ready); end
      step();
      set_req(0, 1'b0, 32'd0, 32'd0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 1'b0, 32'd4, 32'd1, 2'd0}) begin
         n_bad++;
         $display("[TB] FAIL to_next_rsp: got v=%b err=%b q=%0d r=%0d id=%0d want 1/0/4/1/0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_resp_hold();
      int n;
      set_req(2, 1'b1, 32'd7, 32'd7);
      step();
      set_req(2, 1'b0, 32'd0, 32'd0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
      set_req(1, 1'b1, 32'd13, 32'd4);
      for (int i = 0; i < 10; i++) begin
         #1;
         n_cmp++;
         if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.req_ready} !== {1'b1, 32'd1, 32'd0, 2'd2, 4'b0000}) begin
            n_bad++;
            $display("[TB] FAIL hold[%0d]: got v=%b q=%0d r=%0d id=%0d rdy=%b want 1/1/0/2/0000",
                     i, bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.req_ready);
         end
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0010) begin n_bad++; $display("[TB] FAIL hold_next_grant: got %b want 0010", bus.req_ready); end
      step();
      set_req(1, 1'b0, 32'd0, 32'd0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 32'd3, 32'd1, 2'd1}) begin
         n_bad++;
         $display("[TB] FAIL hold_next_rsp: got v=%b q=%0d r=%0d id=%0d want 1/3/1/1",
                  bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_busy();
      int n;
      set_req(3, 1'b1, 32'd30, 32'd5);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b1000) begin n_bad++; $display("[TB] FAIL rb_grant: got %b want 1000", bus.req_ready); end
      step();
      set_req(3, 1'b0, 32'd0, 32'd0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_cmp++;
      if ({bus.rsp_valid, bus.div_valid_in, bus.req_ready, bus.rsp_q, bus.rsp_r, bus.rsp_id,
           bus.div_zdividend, bus.div_zdivisor, bus.rsp_err, bus.rsp_dz} !== '0) begin
         n_bad++;
         $display("[TB] FAIL rb_outputs: got v=%b dvi=%b q=%h a=%h b=%h id=%0d want all 0",
                  bus.rsp_valid, bus.div_valid_in, bus.rsp_q, bus.div_zdividend, bus.div_zdivisor, bus.rsp_id);
      end
      for (int i = 0; i < 6; i++) begin
         force_done = (i == 4);
         step();
         n_cmp++;
         if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rb_spurious[%0d]: got rsp_valid=%b want 0", i, bus.rsp_valid); end
      end
      force_done = 1'b0;
      set_req(0, 1'b1, 32'd8, 32'd2);
      set_req(3, 1'b1, 32'd8, 32'd2);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_bad++; $display("[TB] FAIL rb_ptr: got %b want 0001", bus.req_ready); end
      step();
      set_req(0, 1'b0, 32'd0, 32'd0);
      set_req(3, 1'b0, 32'd0, 32'd0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 32'd4, 32'd0, 2'd0}) begin
         n_bad++;
         $display("[TB] FAIL rb_after_rsp: got v=%b q=%0d r=%0d id=%0d want 1/4/0/0",
                  bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.req_sign     = '0;
      bus.rsp_ready    = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_div_zero();
      test_issue_stall();
      test_timeout();
      test_resp_hold();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Round-robin scheduler that shares one radix-2 divider instance (top_r2, WIDTH-bit) between NREQ requesters.
- Accepts one request at a time, launches it on the divider's valid_in/free handshake and waits for done.
- Returns q/r/sign_o tagged with the requester ID.
- Handles divide-by-zero locally without using the divider; flags a divider hang with a watchdog.

Parameters:
- WIDTH, 32, operand/result width; must match the divider.
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, 64, max cycles waiting for div_done before abort.
- IDW (localparam), $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant/accept, same cycle as acceptance
- req_dividend  in  NREQ*WIDTH  packed, requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed as above
- req_sign  in  NREQ  signed-operation select per requester
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that owns the response
- rsp_q  out  WIDTH  quotient
- rsp_r  out  WIDTH  remainder
- rsp_sign  out  1  result sign (from div_sign_o)
- rsp_dz  out  1  divide-by-zero response
- rsp_err  out  1  timeout response; q/r invalid
- div_zdividend  out  WIDTH  to divider zdividend
- div_zdivisor  out  WIDTH  to divider zdivisor
- div_sign  out  1  to divider sign
- div_valid_in  out  1  to divider valid_in
- div_free  in  1  divider idle
- div_done  in  1  divider result pulse
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder
- div_sign_o  in  1  divider result sign

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): state IDLE, all outputs 0, RR pointer = NREQ-1 (requester 0 wins first), timer 0. Reset mid-operation aborts silently; no response is produced.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE, any req_valid:
  - Pick the first set bit searching from ptr+1 with wrap.
  - req_ready[g]=1 combinationally this cycle only.
  - Latch operands, sign and id=g.
  - Latched divisor==0 -> RESP with rsp_q='1, rsp_r=dividend, rsp_sign=req_sign, rsp_dz=1.
  - Otherwise -> ISSUE.
- ISSUE:
  - div_valid_in=1, div_* driven from latches (registered, stable).
  - If div_free=1 this cycle -> BUSY, timer cleared.
  - Otherwise hold valid and retry; the timer runs in ISSUE too.
- BUSY:
  - div_valid_in=0; timer increments each cycle.
  - div_done=1 -> capture div_q/div_r/div_sign_o into rsp regs -> RESP.
  - Timer==TIMEOUT-1 without done -> RESP with rsp_err=1, q/r=0.
  - done and timeout in the same cycle: done wins, err=0.
- RESP:
  - rsp_valid=1; all rsp_* stable until rsp_ready.
  - rsp_ready=1 -> IDLE, ptr<=id, rsp_valid deasserts next cycle.
  - No new request is accepted while in RESP; single outstanding op.
- div_done outside BUSY is ignored.
- req_ready is never asserted outside IDLE.
- Latency with a free divider:
  - accept at T, div_valid_in at T+1, BUSY at T+2.
  - div_done at cycle D -> rsp_valid at D+1.
  - Divide-by-zero: rsp_valid at T+1.
- Requesters must hold req_valid and operands stable until req_ready. Dropping req_valid before grant is legal and loses nothing.

Decomposition:
- Package div_arb_pkg: state enum (IDLE/ISSUE/BUSY/RESP), DZ_QUOT constant ('1), default TIMEOUT.
- Sub-module rr_pick: NREQ-wide combinational round-robin picker (req vector, ptr -> one-hot grant + index), reusable by other shared-unit schedulers.

Test Plan:
- Single request, req0 100/7 unsigned, divider free -> req_ready[0] at T, div_valid_in at T+1, rsp_q=14 rsp_r=2 rsp_id=0 one cycle after div_done.
- All four requesting continuously, each rsp_ready=1 -> grant order 0,1,2,3,0; no requester granted twice before the others.
- req2 divisor=0, dividend=0x1234 -> no div_valid_in; rsp_valid at T+1 with q=0xFFFFFFFF r=0x1234 dz=1 id=2.
- div_free held 0 for 5 cycles in ISSUE -> div_valid_in stays 1 with stable operands; BUSY entered on the first free cycle.
- Divider model never asserts done, TIMEOUT=64 -> rsp_err=1 exactly 64 cycles after ISSUE exit; next request still serviced.
- rsp_ready held 0 for 10 cycles with req1 pending -> rsp_* stable, req_ready stays 0; rst_n=0 during BUSY -> all outputs 0 next cycle, ptr reset, later spurious div_done ignored.
